// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   arb_state_e : port FSM state encoding (IDLE, BUSY_I, BUSY_D)
//   PORT_I/D    : port identifiers used by the round-robin picker and last_grant
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector.
//   req_i, req_d : pending requests from the fetch and data ports
//   last_grant   : port that won the previous arbitration
//   grant_valid  : at least one request is pending
//   grant_port   : winning port (PORT_I / PORT_D)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) begin
            // tie: the port that did not win last time goes first
            grant_port = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            grant_port = PORT_D;
        end else begin
            grant_port = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch
// port (i_*) and the data port (d_*), with a per-access timeout.
//   clk, reset          : clock, asynchronous active-low reset
//   i_req/i_addr        : fetch request in; i_done/i_rdata out
//   d_req/d_we/d_addr/d_wdata : data request in; d_done/d_rdata out
//   err                 : pulses with the done of an access that timed out
//   mem_req/mem_we/mem_addr/mem_wdata : memory request out
//   mem_ready/mem_rdata : memory completion and read data in
//
// state  | meaning
// IDLE   | no access in flight; arbitrate pending requests
// BUSY_I | fetch access issued; waiting for mem_ready or timeout
// BUSY_D | data access issued; waiting for mem_ready or timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    // The edge that would bring the count to TIMEOUT is the last one at
    // which mem_ready can still be accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_valid;
    logic grant_port;

    rr_pick2 u_pick (
        .req_i       (i_req),
        .req_d       (d_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        err_d        = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    if (grant_port == PORT_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    last_grant_d = (state_q == BUSY_D) ? PORT_D : PORT_I;
                    if (state_q == BUSY_D) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                        // an aborted access still counts as this port's turn
                        last_grant_d = (state_q == BUSY_D) ? PORT_D : PORT_I;
                        if (state_q == BUSY_D) begin
                            d_done_d = 1'b1;
                        end else begin
                            i_done_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic P_I = 1'b0;
    localparam logic P_D = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } done_t;

    acc_t  exp_acc[$];
    done_t exp_done[$];
    acc_t  mon_a;
    done_t mon_d;

    int          lat_cfg = 0;   // ready sampled at grant edge + lat_cfg; 0 = never
    logic [31:0] mem_key = '0;  // memory returns addr ^ key on ready
    int          wait_k = 0;
    bit          in_acc = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Memory responder plus scoreboard: accesses and completions are checked
    // in order against what each test pushed.
    always @(negedge clk) begin
        if (!reset) begin
            mem_ready = 1'b0;
            in_acc    = 0;
            wait_k    = 0;
        end else begin
            if (i_done || d_done) begin
                tests++;
                if (exp_done.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: i_done=%0b d_done=%0b err=%0b, none expected", i_done, d_done, err);
                end else begin
                    mon_d = exp_done.pop_front();
                    if ((i_done && d_done) || d_done !== mon_d.port || err !== mon_d.err ||
                        (mon_d.port ? d_rdata : i_rdata) !== mon_d.rdata) begin
                        fails++;
                        $display("FAIL sb_done: got i_done=%0b d_done=%0b err=%0b i_rdata=%h d_rdata=%h, want port=%0b err=%0b rdata=%h",
                                 i_done, d_done, err, i_rdata, d_rdata, mon_d.port, mon_d.err, mon_d.rdata);
                    end
                end
            end
            if (mem_req) begin
                if (!in_acc) begin
                    in_acc = 1;
                    wait_k = 1;
                    tests++;
                    if (exp_acc.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_access: addr=%h we=%0b", mem_addr, mem_we);
                    end else begin
                        mon_a = exp_acc.pop_front();
                        if (mem_addr !== mon_a.addr || mem_we !== mon_a.we ||
                            (mon_a.we && mem_wdata !== mon_a.wdata)) begin
                            fails++;
                            $display("FAIL sb_access: got addr=%h we=%0b wdata=%h, want addr=%h we=%0b wdata=%h",
                                     mem_addr, mem_we, mem_wdata, mon_a.addr, mon_a.we, mon_a.wdata);
                        end
                    end
                end else begin
                    wait_k++;
                end
                mem_ready = (lat_cfg != 0) && (wait_k == lat_cfg);
                mem_rdata = mem_ready ? (mem_addr ^ mem_key) : ~(mem_addr ^ mem_key);
            end else begin
                in_acc    = 0;
                mem_ready = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({mem_req, mem_we, i_done, d_done, err} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_ctrl: req=%0b we=%0b i_done=%0b d_done=%0b err=%0b addr=%h wdata=%h, want all 0",
                     mem_req, mem_we, i_done, d_done, err, mem_addr, mem_wdata);
        end
        tests++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h, want 0", i_rdata, d_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: mem_req=%0b, want 0", mem_req);
        end
    endtask

    task automatic test_single_fetch();
        bit got = 0;
        mem_key = 32'hDEADBEEF ^ 32'h100;
        lat_cfg = 3;
        exp_acc.push_back('{P_I, 1'b0, 32'h100, 32'h0});
        exp_done.push_back('{P_I, 1'b0, 32'hDEADBEEF});
        i_addr = 32'h100;
        i_req  = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests++;
                if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
                    fails++;
                    $display("FAIL fetch_grant: req=%0b we=%0b addr=%h, want 1 0 00000100", mem_req, mem_we, mem_addr);
                end
            end
            if (i_done) begin
                got = 1;
                i_req = 1'b0;
                tests++;
                if (c != 4 || i_rdata !== 32'hDEADBEEF || err !== 1'b0) begin
                    fails++;
                    $display("FAIL fetch_done: cycle=%0d rdata=%h err=%0b, want cycle=4 rdata=deadbeef err=0", c, i_rdata, err);
                end
            end
        end
        if (!got) begin
            tests++; fails++;
            i_req = 1'b0;
            $display("FAIL fetch_wait: no i_done within 20 cycles");
        end
        @(negedge clk);
        tests++;
        if (i_done !== 1'b0 || mem_req !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL fetch_after: i_done=%0b mem_req=%0b i_rdata=%h, want 0 0 deadbeef", i_done, mem_req, i_rdata);
        end
    endtask

    task automatic test_tie_fairness();
        logic [31:0] seq [4];
        mem_key = 32'h5A5A_0000;
        lat_cfg = 1;
        seq[0] = 32'h300; seq[1] = 32'h200; seq[2] = 32'h300; seq[3] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_acc.push_back('{(k % 2 == 0) ? P_D : P_I, 1'b0, seq[k], 32'h0});
            exp_done.push_back('{(k % 2 == 0) ? P_D : P_I, 1'b0, seq[k] ^ mem_key});
        end
        i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            tests++;
            if (c % 2 == 1) begin
                if (mem_req !== 1'b1 || mem_addr !== seq[(c - 1) / 2]) begin
                    fails++;
                    $display("FAIL tie_grant c=%0d: req=%0b addr=%h, want 1 %h", c, mem_req, mem_addr, seq[(c - 1) / 2]);
                end
            end else begin
                if (mem_req !== 1'b0 || d_done !== (c % 4 == 2) || i_done !== (c % 4 == 0)) begin
                    fails++;
                    $display("FAIL tie_done c=%0d: req=%0b d_done=%0b i_done=%0b, want req=0 d_done=%0b i_done=%0b",
                             c, mem_req, d_done, i_done, c % 4 == 2, c % 4 == 0);
                end
            end
            if (c == 6) d_req = 1'b0;
            if (c == 8) i_req = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL tie_end: mem_req=%0b, want 0", mem_req);
        end
    endtask

    task automatic test_store();
        bit got = 0;
        lat_cfg = 2;
        exp_acc.push_back('{P_D, 1'b1, 32'h40, 32'h1234});
        exp_done.push_back('{P_D, 1'b0, 32'h5A5A_0300});
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        d_req = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234 || mem_addr !== 32'h40) begin
                    fails++;
                    $display("FAIL store_grant: req=%0b we=%0b wdata=%h addr=%h, want 1 1 00001234 00000040",
                             mem_req, mem_we, mem_wdata, mem_addr);
                end
            end
            if (d_done) begin
                got = 1;
                d_req = 1'b0;
                tests++;
                if (c != 3 || d_rdata !== 32'h5A5A_0300 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL store_done: cycle=%0d d_rdata=%h err=%0b, want cycle=3 d_rdata=5a5a0300 err=0", c, d_rdata, err);
                end
            end
        end
        if (!got) begin
            tests++; fails++;
            d_req = 1'b0;
            $display("FAIL store_wait: no d_done within 20 cycles");
        end
        d_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        lat_cfg = 0;
        exp_acc.push_back('{P_D, 1'b0, 32'h80, 32'h0});
        exp_acc.push_back('{P_I, 1'b0, 32'h180, 32'h0});
        exp_done.push_back('{P_D, 1'b1, 32'h5A5A_0300});
        exp_done.push_back('{P_I, 1'b0, 32'h5A5A_0180});
        d_we = 1'b0; d_addr = 32'h80; i_addr = 32'h180;
        d_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) i_req = 1'b1;
            if (c == 8) begin
                tests++;
                if (mem_req !== 1'b1 || d_done !== 1'b0 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_early: req=%0b d_done=%0b err=%0b, want 1 0 0", mem_req, d_done, err);
                end
            end
            if (c == 9) begin
                tests++;
                if (d_done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0 || d_rdata !== 32'h5A5A_0300) begin
                    fails++;
                    $display("FAIL timeout_abort: d_done=%0b err=%0b req=%0b d_rdata=%h, want 1 1 0 5a5a0300",
                             d_done, err, mem_req, d_rdata);
                end
                d_req = 1'b0;
                lat_cfg = 2;
            end
            if (c == 10) begin
                tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h180 || err !== 1'b0 || d_done !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_next: req=%0b addr=%h err=%0b d_done=%0b, want 1 00000180 0 0",
                             mem_req, mem_addr, err, d_done);
                end
            end
            if (c == 12) begin
                tests++;
                if (i_done !== 1'b1 || i_rdata !== 32'h5A5A_0180) begin
                    fails++;
                    $display("FAIL timeout_fetch: i_done=%0b i_rdata=%h, want 1 5a5a0180", i_done, i_rdata);
                end
                i_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_boundary();
        lat_cfg = 8;
        exp_acc.push_back('{P_D, 1'b0, 32'hC0, 32'h0});
        exp_done.push_back('{P_D, 1'b0, 32'h5A5A_00C0});
        d_we = 1'b0; d_addr = 32'hC0;
        d_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 8) begin
                tests++;
                if (d_done !== 1'b0 || mem_req !== 1'b1) begin
                    fails++;
                    $display("FAIL boundary_early: d_done=%0b req=%0b, want 0 1", d_done, mem_req);
                end
            end
            if (c == 9) begin
                tests++;
                if (d_done !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h5A5A_00C0) begin
                    fails++;
                    $display("FAIL boundary_done: d_done=%0b err=%0b d_rdata=%h, want 1 0 5a5a00c0", d_done, err, d_rdata);
                end
                d_req = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || d_done !== 1'b0) begin
            fails++;
            $display("FAIL boundary_after: req=%0b d_done=%0b, want 0 0", mem_req, d_done);
        end
    endtask

    task automatic test_reset_mid_access();
        lat_cfg = 0;
        exp_acc.push_back('{P_D, 1'b0, 32'h20, 32'h0});
        d_we = 1'b0; d_addr = 32'h20;
        d_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
                    fails++;
                    $display("FAIL rstmid_grant: req=%0b addr=%h, want 1 00000020", mem_req, mem_addr);
                end
            end
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({mem_req, mem_we, i_done, d_done, err} !== 5'b0 || mem_addr !== 32'h0 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_async: req=%0b we=%0b i_done=%0b d_done=%0b err=%0b addr=%h i_rdata=%h d_rdata=%h, want all 0",
                     mem_req, mem_we, i_done, d_done, err, mem_addr, i_rdata, d_rdata);
        end
        i_addr = 32'h1C0;
        i_req  = 1'b1;
        repeat (2) @(negedge clk);
        lat_cfg = 1;
        exp_acc.push_back('{P_D, 1'b0, 32'h20, 32'h0});
        exp_acc.push_back('{P_I, 1'b0, 32'h1C0, 32'h0});
        exp_done.push_back('{P_D, 1'b0, 32'h5A5A_0020});
        exp_done.push_back('{P_I, 1'b0, 32'h5A5A_01C0});
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
                    fails++;
                    $display("FAIL rstmid_first: req=%0b addr=%h, want D grant addr 00000020", mem_req, mem_addr);
                end
            end
            if (c == 2) begin
                tests++;
                if (d_done !== 1'b1 || d_rdata !== 32'h5A5A_0020) begin
                    fails++;
                    $display("FAIL rstmid_ddone: d_done=%0b d_rdata=%h, want 1 5a5a0020", d_done, d_rdata);
                end
                d_req = 1'b0;
            end
            if (c == 4) begin
                tests++;
                if (i_done !== 1'b1 || i_rdata !== 32'h5A5A_01C0) begin
                    fails++;
                    $display("FAIL rstmid_idone: i_done=%0b i_rdata=%h, want 1 5a5a01c0", i_done, i_rdata);
                end
                i_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie_fairness();
        test_store();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        tests++;
        if (exp_acc.size() != 0 || exp_done.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: accesses=%0d dones=%0d still expected, want 0 0", exp_acc.size(), exp_done.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
